fifo_wr_arbiter: RTL
====================

Name: fifo_wr_arbiter

Overview:
- Round-robin write arbiter that shares the single write port of the team's `fifo` block among NUM_REQ producers.
- Each producer has a valid/ready handshake. The arbiter drives the FIFO's `w_valid`/`data_in` and obeys `fifo_full`.
- Ownership is held for bursts of up to BURST beats for locality, then passes to the next requester.
- Sits directly in front of the `fifo` write side. The FIFO read side is untouched.

Parameters:
- WIDTH, 32: data width; matches the FIFO WIDTH.
- NUM_REQ, 4: number of requesters, >=2.
- BURST, 4: max accepted beats per grant, >=1.
- IDW, $clog2(NUM_REQ): owner-ID width; derived, not overridden.

Ports:
- clk, input, 1: clock; all state on rising edge.
- reset, input, 1: asynchronous, active-low reset.
- req_valid, input, NUM_REQ: bit i = requester i has data.
- req_data, input, NUM_REQ*WIDTH: slice [i*WIDTH +: WIDTH] = requester i data.
- req_ready, output, NUM_REQ: bit i = beat of requester i accepted this cycle.
- fifo_full, input, 1: from FIFO; a write is taken only when low.
- w_valid, output, 1: FIFO write strobe.
- data_in, output, WIDTH: FIFO write data.
- grant_id, output, IDW: current owner; meaningful only when busy=1.
- busy, output, 1: an owner is granted (state OWNED).
- xfer_cnt, output, 16: total accepted beats; saturates at 0xFFFF.

Behaviour:
- Reset (async assert, sync release) sets:
  - state=IDLE, rr_ptr=0, owner=0, beat_cnt=0, xfer_cnt=0.
  - Outputs w_valid=0, req_ready=0, data_in=0, grant_id=0, busy=0.
- Accept condition: accept = w_valid & !fifo_full (one beat). Because the FIFO only writes when not full, a beat presented while full is not lost; it is held.
- Combinational outputs:
  - busy = (state==OWNED).
  - w_valid = busy & req_valid[owner].
  - data_in = w_valid ? req_data[owner] : 0.
  - req_ready[i] = busy & (i==owner) & !fifo_full; all other bits are 0.
  - grant_id = owner.
- Requester rule: once req_valid is raised, data must be held stable until req_ready. A requester may drop valid only after an accepted beat.
- FSM IDLE:
  - If any req_valid is high: select the first set bit searching rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_REQ. Then owner<=sel, beat_cnt<=0, state<=OWNED.
  - No transfer occurs in IDLE. Grant latency is 1 cycle from req_valid to the first possible beat.
- FSM OWNED, priority order:
  - (a) If accept and beat_cnt==BURST-1: state<=IDLE, rr_ptr<=(owner+1) mod NUM_REQ.
  - (b) Else if !req_valid[owner]: state<=IDLE, rr_ptr<=(owner+1) mod NUM_REQ. Voluntary release; no beat that cycle.
  - (c) Else stay in OWNED; if accept, beat_cnt<=beat_cnt+1.
- Each burst release costs exactly 1 IDLE cycle. Steady state with all requesters active is BURST beats per BURST+1 cycles.
- fifo_full during OWNED:
  - Owner is kept and beat_cnt is frozen.
  - w_valid stays 1 with data held; req_ready=0.
  - No timeout; full never forces a release.
- Non-owners' req_valid has no effect while OWNED.
- xfer_cnt increments by 1 per accept and holds at 0xFFFF.
- With NUM_REQ not a power of 2, the rr_ptr wrap is explicit: NUM_REQ-1 wraps to 0.
- Reset mid-burst:
  - All outputs drop to reset values immediately.
  - After release, arbitration restarts from requester 0.
  - A beat in flight in the reset cycle is not counted.

Test Plan:
- Reset: assert reset=0 with req_valid=4'hF → w_valid=0, req_ready=0, busy=0, grant_id=0, xfer_cnt=0; held for the whole reset.
- Single requester: req 2 streams 0xA0..0xA5 with fifo_full=0.
  - busy rises 1 cycle after valid.
  - Beats 0xA0–0xA3 on 4 consecutive cycles, then 1 IDLE cycle.
  - Regrant to 2 (rr_ptr=3 wraps to 2); 0xA4, 0xA5 follow.
  - xfer_cnt=6.
- All four requesters valid continuously → grant_id sequence 0,1,2,3,0 with 4 beats each, 1 IDLE gap between grants; 16 beats in 20 cycles.
- fifo_full=1 for 3 cycles after beat 2 of owner 1:
  - w_valid=1, data_in stable, req_ready=0, beat_cnt stays 2.
  - After full deasserts, beats 3–4 complete, then release to owner 2.
- Owner 0 drops valid after 2 accepted beats with req 3 pending → IDLE next cycle, rr_ptr=1, grant_id=3 one cycle later.
- Reset pulse while owner 1 is at beat 2 of 4 → outputs zero asynchronously; after release with req 0 and req 1 valid, grant_id=0 first.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst write arbiter for the fifo write port
module fifo_wr_arbiter #(
  parameter  int WIDTH   = 32,
  parameter  int NUM_REQ = 4,
  parameter  int BURST   = 4,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic                     fifo_full,
  output logic                     w_valid,
  output logic [WIDTH-1:0]         data_in,
  output logic [IDW-1:0]           grant_id,
  output logic                     busy,
  output logic [15:0]              xfer_cnt
);

  localparam int BCW = (BURST > 1) ? $clog2(BURST) : 1;

  typedef enum logic {IDLE, OWNED} state_t;

  state_t         state, state_nx;
  logic [IDW-1:0] owner, owner_nx, rr_ptr, rr_ptr_nx, sel, owner_inc;
  logic [BCW-1:0] beat_cnt, beat_cnt_nx;
  logic           accept;
  logic [WIDTH-1:0] data_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign data_arr[g] = req_data[g*WIDTH +: WIDTH];
  end

  assign busy      = (state == OWNED);
  assign w_valid   = busy & req_valid[owner];
  assign accept    = w_valid & ~fifo_full;
  assign data_in   = w_valid ? data_arr[owner] : '0;
  assign grant_id  = owner;
  assign owner_inc = (owner == IDW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = busy & (owner == IDW'(i)) & ~fifo_full;
    end
  end

  // Scan from the farthest candidate back toward rr_ptr so the nearest valid one wins.
  always_comb begin : sel_p
    int idx;
    sel = '0;
    idx = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req_valid[idx]) sel = IDW'(idx);
    end
  end

  always_comb begin
    state_nx    = state;
    owner_nx    = owner;
    rr_ptr_nx   = rr_ptr;
    beat_cnt_nx = beat_cnt;
    case (state)
      IDLE: begin
        if (|req_valid) begin
          owner_nx    = sel;
          beat_cnt_nx = '0;
          state_nx    = OWNED;
        end
      end
      OWNED: begin
        if (accept && beat_cnt == BCW'(BURST - 1)) begin
          state_nx  = IDLE;
          rr_ptr_nx = owner_inc;
        end else if (!req_valid[owner]) begin
          state_nx  = IDLE;
          rr_ptr_nx = owner_inc;
        end else if (accept) begin
          beat_cnt_nx = beat_cnt + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
      xfer_cnt <= '0;
    end else begin
      state    <= state_nx;
      owner    <= owner_nx;
      rr_ptr   <= rr_ptr_nx;
      beat_cnt <= beat_cnt_nx;
      if (accept && xfer_cnt != 16'hFFFF) xfer_cnt <= xfer_cnt + 16'd1;
    end
  end

endmodule
